player_motion_n: RTL and testbench
==================================

PLAYER_MOTION_N -- requirements
Module: player_motion_n

Interface
REQ-001 Parameter NPLAYERS, default 2: number of independent players (1..8).
REQ-002 Parameter HACTIVE, default 800: active width in pixels.
REQ-003 Parameter VACTIVE, default 600: active height in pixels.
REQ-004 Parameter SPRITE, default 32: sprite side in pixels.
REQ-005 Parameter STEP, default 1: pixels moved per motion frame (1..SPRITE).
REQ-006 Parameter STEP_DIV, default 1: motion occurs once every STEP_DIV frames (1..16).
REQ-007 Parameter ANIM_DIV, default 8: motion frames per walk-animation phase toggle (1..64).
REQ-008 Parameters SPAWN_X0 (400), SPAWN_DX (50), SPAWN_Y (300): player i spawns at (SPAWN_X0+i*SPAWN_DX, SPAWN_Y).
REQ-009 clk  in  1  system clock; the only clock.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 eof  in  1  end-of-frame; may stay high several cycles.
REQ-012 up, down, left, right  in  NPLAYERS each  level-held direction commands, bit i = player i.
REQ-013 center_x, center_y  out  NPLAYERS x 10  player top-left position, registered.
REQ-014 sprite_num  out  NPLAYERS x 3  sprite index to display, registered.
REQ-015 moving  out  NPLAYERS  player i has a non-null motion request, registered.
REQ-016 frame_tick  out  1  one-cycle pulse on the rising edge of eof.

Function
REQ-017 frame_tick SHALL be 1 exactly in the cycle after eof goes 0->1; a held eof SHALL yield one pulse.
REQ-018 A divider SHALL count frame_tick modulo STEP_DIV; a motion frame is a frame_tick with divider at 0.
REQ-019 Positions SHALL update only in the cycle following a motion frame (eof rise to new center = 2 cycles).
REQ-020 Per axis: up XOR down selects Y direction, left XOR right selects X direction; both or neither pressed = no motion on that axis.
REQ-021 X and Y SHALL move independently in the same motion frame (diagonal allowed).
REQ-022 Moves SHALL saturate: Y clamped to [0, VACTIVE-SPRITE], X to [0, HACTIVE-SPRITE]; a partial step lands exactly on the bound; no wrap-around.
REQ-023 Subtraction SHALL be evaluated with one guard bit so a value below 0 clamps to 0, never wraps to 1023.
REQ-024 moving[i] SHALL be 1 when either axis of player i has a non-null direction, updated every cycle.
REQ-025 Per player, a walk FSM: IDLE (moving=0) -> WALK on moving=1; WALK -> IDLE on moving=0, same cycle.
REQ-026 In WALK, an anim counter SHALL count motion frames; at ANIM_DIV-1 it wraps to 0 and toggles phase bit.
REQ-027 Entering IDLE SHALL clear anim counter and phase.
REQ-028 Facing: vertical motion takes priority; else left; else right; held while idle (for diagnostics only).
REQ-029 sprite_num: IDLE=2; WALK vertical=0+phase; WALK right=3+phase; WALK left=5+phase; one-cycle latency from inputs.
REQ-030 Players SHALL be fully independent; no collision between players.

Reset
REQ-031 On reset: center_x[i]=SPAWN_X0+i*SPAWN_DX, center_y[i]=SPAWN_Y, clamped to bounds.
REQ-032 On reset: sprite_num=2, moving=0, frame_tick=0, divider=0, all FSMs IDLE, anim counters and phase 0, eof history 0.
REQ-033 Reset mid-motion SHALL abort immediately; first motion after release needs a fresh eof rising edge.

Structure
REQ-034 Shared package SHALL hold the sprite index constants (SPR_IDLE=2, SPR_VERT=0, SPR_RIGHT=3, SPR_LEFT=5) and the walk-state enum.
REQ-035 One sub-module player_axis_step SHALL implement one clamped axis update (position, dir, step, max), instantiated 2*NPLAYERS times.

Verification
REQ-036 Defaults, hold right[0], 10 eof pulses -> center_x[0] 400->410, center_y[0]=300, sprite_num[0] alternates 3/4 every 8 frames.
REQ-037 STEP=4, player 1 at Y=2, hold up, 1 eof -> center_y[1]=0; further eofs keep 0.
REQ-038 Hold left and right together on player 0 over 5 eofs -> center_x unchanged, moving=0, sprite_num=2.
REQ-039 STEP_DIV=3, hold down, 9 eof pulses (one held 5 cycles) -> center_y advances by exactly 3.
REQ-040 Assert reset during WALK at (420,300) -> outputs return to spawn values and sprite_num=2 asynchronously.
REQ-041 NPLAYERS=4, up[3] and right[2] held, 1 eof -> only players 2 and 3 move, by 1 pixel each.

Source files
------------

// File: rtl/player_motion_n_pkg.sv
// Shared types and constants for the multi-player motion block.
package player_motion_n_pkg;

  localparam logic [2:0] SPR_VERT  = 3'd0;
  localparam logic [2:0] SPR_IDLE  = 3'd2;
  localparam logic [2:0] SPR_RIGHT = 3'd3;
  localparam logic [2:0] SPR_LEFT  = 3'd5;

  typedef enum logic {ST_IDLE = 1'b0, ST_WALK = 1'b1} walk_state_t;

  typedef enum logic [1:0] {FACE_VERT = 2'd0, FACE_LEFT = 2'd1, FACE_RIGHT = 2'd2} facing_t;

  function automatic logic [9:0] clamp_spawn(input int v, input int hi);
    int r;
    r = (v < 0) ? 0 : ((v > hi) ? hi : v);
    return r[9:0];
  endfunction

endpackage

// File: rtl/player_axis_step.sv
// One saturating axis update; the 11-bit intermediates carry a guard bit so
// underflow clamps to 0 and overflow clamps to MAX.
module player_axis_step #(
  parameter int STEP = 1,
  parameter int MAX  = 768
) (
  input  logic [9:0] pos,
  input  logic       inc,
  input  logic       dec,
  output logic [9:0] pos_next
);

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] MAX_W  = 11'(MAX);

  logic [10:0] sum;
  logic [10:0] diff;

  always_comb begin
    sum      = {1'b0, pos} + STEP_W;
    diff     = {1'b0, pos} - STEP_W;
    pos_next = pos;
    if (inc && !dec)
      pos_next = (sum > MAX_W) ? MAX_W[9:0] : sum[9:0];
    else if (dec && !inc)
      pos_next = diff[10] ? 10'd0 : diff[9:0];
  end

endmodule

// File: rtl/player_motion_n.sv
// Frame-paced motion, walk animation and sprite selection for NPLAYERS
// independent players.
//   state   | meaning
//   ST_IDLE | no net direction pressed; sprite is SPR_IDLE, anim cleared
//   ST_WALK | some axis active; anim counter runs on motion frames
module player_motion_n
  import player_motion_n_pkg::*;
#(
  parameter int NPLAYERS = 2,
  parameter int HACTIVE  = 800,
  parameter int VACTIVE  = 600,
  parameter int SPRITE   = 32,
  parameter int STEP     = 1,
  parameter int STEP_DIV = 1,
  parameter int ANIM_DIV = 8,
  parameter int SPAWN_X0 = 400,
  parameter int SPAWN_DX = 50,
  parameter int SPAWN_Y  = 300
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     eof,
  input  logic [NPLAYERS-1:0]      up,
  input  logic [NPLAYERS-1:0]      down,
  input  logic [NPLAYERS-1:0]      left,
  input  logic [NPLAYERS-1:0]      right,
  output logic [NPLAYERS-1:0][9:0] center_x,
  output logic [NPLAYERS-1:0][9:0] center_y,
  output logic [NPLAYERS-1:0][2:0] sprite_num,
  output logic [NPLAYERS-1:0]      moving,
  output logic                     frame_tick
);

  localparam int XMAX = HACTIVE - SPRITE;
  localparam int YMAX = VACTIVE - SPRITE;
  localparam int DW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int AW   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic          eof_d;
  logic [DW-1:0] div_q;
  logic          motion_frame;

  assign motion_frame = frame_tick && (div_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eof_d      <= 1'b0;
      frame_tick <= 1'b0;
      div_q      <= '0;
    end else begin
      eof_d      <= eof;
      frame_tick <= eof & ~eof_d;
      if (frame_tick)
        div_q <= (div_q == DW'(STEP_DIV - 1)) ? '0 : div_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NPLAYERS; i++) begin : g_pl
    localparam logic [9:0] SX = clamp_spawn(SPAWN_X0 + i * SPAWN_DX, XMAX);
    localparam logic [9:0] SY = clamp_spawn(SPAWN_Y, YMAX);

    logic          x_inc, x_dec, y_inc, y_dec, mv;
    logic [9:0]    x_q, y_q, x_nx, y_nx;
    walk_state_t   st_q, st_n;
    facing_t       face_q, face_n;
    logic [AW-1:0] cnt_q, cnt_n;
    logic          ph_q, ph_n;
    logic [2:0]    spr_q, spr_n;
    logic          mv_q;

    assign x_inc = right[i] & ~left[i];
    assign x_dec = left[i]  & ~right[i];
    assign y_inc = down[i]  & ~up[i];
    assign y_dec = up[i]    & ~down[i];
    assign mv    = x_inc | x_dec | y_inc | y_dec;

    player_axis_step #(.STEP(STEP), .MAX(XMAX)) u_x (
      .pos(x_q), .inc(x_inc), .dec(x_dec), .pos_next(x_nx)
    );
    player_axis_step #(.STEP(STEP), .MAX(YMAX)) u_y (
      .pos(y_q), .inc(y_inc), .dec(y_dec), .pos_next(y_nx)
    );

    always_comb begin
      st_n   = mv ? ST_WALK : ST_IDLE;
      face_n = face_q;
      cnt_n  = cnt_q;
      ph_n   = ph_q;
      spr_n  = SPR_IDLE;
      if (y_inc || y_dec)  face_n = FACE_VERT;
      else if (x_dec)      face_n = FACE_LEFT;
      else if (x_inc)      face_n = FACE_RIGHT;
      if (st_n == ST_IDLE) begin
        cnt_n = '0;
        ph_n  = 1'b0;
      end else if (st_q == ST_WALK && motion_frame) begin
        if (cnt_q == AW'(ANIM_DIV - 1)) begin
          cnt_n = '0;
          ph_n  = ~ph_q;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      if (st_n == ST_WALK) begin
        case (face_n)
          FACE_VERT: spr_n = SPR_VERT  + {2'b00, ph_n};
          FACE_LEFT: spr_n = SPR_LEFT  + {2'b00, ph_n};
          default:   spr_n = SPR_RIGHT + {2'b00, ph_n};
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        x_q    <= SX;
        y_q    <= SY;
        st_q   <= ST_IDLE;
        face_q <= FACE_VERT;
        cnt_q  <= '0;
        ph_q   <= 1'b0;
        spr_q  <= SPR_IDLE;
        mv_q   <= 1'b0;
      end else begin
        st_q   <= st_n;
        face_q <= face_n;
        cnt_q  <= cnt_n;
        ph_q   <= ph_n;
        spr_q  <= spr_n;
        mv_q   <= mv;
        if (motion_frame) begin
          x_q <= x_nx;
          y_q <= y_nx;
        end
      end
    end

    assign center_x[i]   = x_q;
    assign center_y[i]   = y_q;
    assign sprite_num[i] = spr_q;
    assign moving[i]     = mv_q;
  end

endmodule

// File: tb/tb_player_motion_n.sv
// Scoreboard bench for player_motion_n: four parameter variants share clock,
// reset and eof; each scenario pushes expected per-frame results and pops them.
module tb_player_motion_n;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic eof = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] a_up, a_dn, a_lf, a_rt, b_up, b_dn, b_lf, b_rt, c_up, c_dn, c_lf, c_rt;
  logic [3:0] d_up, d_dn, d_lf, d_rt;
  logic [1:0][9:0] a_cx, a_cy, b_cx, b_cy, c_cx, c_cy;
  logic [1:0][2:0] a_spr, b_spr, c_spr;
  logic [1:0]      a_mv, b_mv, c_mv;
  logic [3:0][9:0] d_cx, d_cy;
  logic [3:0][2:0] d_spr;
  logic [3:0]      d_mv;
  logic a_ft, b_ft, c_ft, d_ft;

  player_motion_n dut_a (
    .clk(clk), .reset(reset), .eof(eof), .up(a_up), .down(a_dn), .left(a_lf), .right(a_rt),
    .center_x(a_cx), .center_y(a_cy), .sprite_num(a_spr), .moving(a_mv), .frame_tick(a_ft));
  player_motion_n #(.STEP(4), .SPAWN_Y(2)) dut_b (
    .clk(clk), .reset(reset), .eof(eof), .up(b_up), .down(b_dn), .left(b_lf), .right(b_rt),
    .center_x(b_cx), .center_y(b_cy), .sprite_num(b_spr), .moving(b_mv), .frame_tick(b_ft));
  player_motion_n #(.STEP_DIV(3)) dut_c (
    .clk(clk), .reset(reset), .eof(eof), .up(c_up), .down(c_dn), .left(c_lf), .right(c_rt),
    .center_x(c_cx), .center_y(c_cy), .sprite_num(c_spr), .moving(c_mv), .frame_tick(c_ft));
  player_motion_n #(.NPLAYERS(4)) dut_d (
    .clk(clk), .reset(reset), .eof(eof), .up(d_up), .down(d_dn), .left(d_lf), .right(d_rt),
    .center_x(d_cx), .center_y(d_cy), .sprite_num(d_spr), .moving(d_mv), .frame_tick(d_ft));

  typedef struct {
    int x;
    int y;
    int spr;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic clear_inputs();
    a_up = '0; a_dn = '0; a_lf = '0; a_rt = '0;
    b_up = '0; b_dn = '0; b_lf = '0; b_rt = '0;
    c_up = '0; c_dn = '0; c_lf = '0; c_rt = '0;
    d_up = '0; d_dn = '0; d_lf = '0; d_rt = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    eof = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // eof rises, two edges pass: the position update is now visible
  task automatic eof_start();
    @(negedge clk);
    eof = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic eof_end(input int extra);
    repeat (extra) @(negedge clk);
    eof = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int sx;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      sx = 400 + i * 50;
      checks++; if (a_cx[i] !== 10'(sx)) begin errors++; $display("FAIL reset_x[%0d] got=%0d exp=%0d", i, a_cx[i], sx); end
      checks++; if (a_cy[i] !== 10'd300) begin errors++; $display("FAIL reset_y[%0d] got=%0d exp=300", i, a_cy[i]); end
      checks++; if (a_spr[i] !== 3'd2) begin errors++; $display("FAIL reset_spr[%0d] got=%0d exp=2", i, a_spr[i]); end
    end
    checks++; if (a_mv !== 2'b00) begin errors++; $display("FAIL reset_moving got=%b exp=00", a_mv); end
    checks++; if (a_ft !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", a_ft); end
    checks++; if (d_cx[3] !== 10'd550) begin errors++; $display("FAIL reset_x4p[3] got=%0d exp=550", d_cx[3]); end
  endtask

  task automatic test_frame_tick();
    @(negedge clk);
    eof = 1'b1;
    @(negedge clk);
    checks++; if (a_ft !== 1'b1) begin errors++; $display("FAIL tick_pulse got=%b exp=1", a_ft); end
    @(negedge clk);
    checks++; if (a_ft !== 1'b0) begin errors++; $display("FAIL tick_width got=%b exp=0", a_ft); end
    repeat (4) @(negedge clk);
    checks++; if (a_ft !== 1'b0) begin errors++; $display("FAIL tick_held got=%b exp=0", a_ft); end
    eof = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_walk_right();
    exp_t e, o;
    int x, cnt, ph;
    apply_reset();
    a_rt[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (a_mv[0] !== 1'b1) begin errors++; $display("FAIL walk_moving got=%b exp=1", a_mv[0]); end
    checks++; if (a_spr[0] !== 3'd3) begin errors++; $display("FAIL walk_spr0 got=%0d exp=3", a_spr[0]); end
    x = 400; cnt = 0; ph = 0;
    for (int f = 0; f < 10; f++) begin
      x++;
      if (cnt == 7) begin cnt = 0; ph ^= 1; end else cnt++;
      e.x = x; e.y = 300; e.spr = 3 + ph;
      sb.push_back(e);
      eof_start();
      o = sb.pop_front();
      checks++; if (a_cx[0] !== 10'(o.x)) begin errors++; $display("FAIL walk_x f%0d got=%0d exp=%0d", f, a_cx[0], o.x); end
      checks++; if (a_cy[0] !== 10'(o.y)) begin errors++; $display("FAIL walk_y f%0d got=%0d exp=%0d", f, a_cy[0], o.y); end
      checks++; if (a_spr[0] !== 3'(o.spr)) begin errors++; $display("FAIL walk_spr f%0d got=%0d exp=%0d", f, a_spr[0], o.spr); end
      eof_end(0);
    end
    checks++; if (a_cx[1] !== 10'd450) begin errors++; $display("FAIL walk_other_x got=%0d exp=450", a_cx[1]); end
  endtask

  task automatic test_both_pressed();
    exp_t e, o;
    a_lf[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      e.x = 410; e.y = 300; e.spr = 2;
      sb.push_back(e);
      eof_start();
      o = sb.pop_front();
      checks++; if (a_cx[0] !== 10'(o.x)) begin errors++; $display("FAIL both_x f%0d got=%0d exp=%0d", f, a_cx[0], o.x); end
      checks++; if (a_spr[0] !== 3'(o.spr)) begin errors++; $display("FAIL both_spr f%0d got=%0d exp=%0d", f, a_spr[0], o.spr); end
      checks++; if (a_mv[0] !== 1'b0) begin errors++; $display("FAIL both_moving f%0d got=%b exp=0", f, a_mv[0]); end
      eof_end(0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    a_rt[0] = 1'b1;
    for (int f = 0; f < 20; f++) begin
      eof_start();
      eof_end(0);
    end
    checks++; if (a_cx[0] !== 10'd420) begin errors++; $display("FAIL mid_pre_x got=%0d exp=420", a_cx[0]); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (a_cx[0] !== 10'd400) begin errors++; $display("FAIL mid_async_x got=%0d exp=400", a_cx[0]); end
    checks++; if (a_cy[0] !== 10'd300) begin errors++; $display("FAIL mid_async_y got=%0d exp=300", a_cy[0]); end
    checks++; if (a_spr[0] !== 3'd2) begin errors++; $display("FAIL mid_async_spr got=%0d exp=2", a_spr[0]); end
    checks++; if (a_mv[0] !== 1'b0) begin errors++; $display("FAIL mid_async_moving got=%b exp=0", a_mv[0]); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (a_cx[0] !== 10'd400) begin errors++; $display("FAIL mid_no_eof_x got=%0d exp=400", a_cx[0]); end
    eof_start();
    checks++; if (a_cx[0] !== 10'd401) begin errors++; $display("FAIL mid_first_x got=%0d exp=401", a_cx[0]); end
    eof_end(0);
  endtask

  task automatic test_clamp_top();
    exp_t e, o;
    int y;
    apply_reset();
    b_up[1] = 1'b1;
    y = 2;
    for (int f = 0; f < 3; f++) begin
      y = (y < 4) ? 0 : y - 4;
      e.x = 450; e.y = y; e.spr = 0;
      sb.push_back(e);
      eof_start();
      o = sb.pop_front();
      checks++; if (b_cy[1] !== 10'(o.y)) begin errors++; $display("FAIL clamp_y f%0d got=%0d exp=%0d", f, b_cy[1], o.y); end
      checks++; if (b_cx[1] !== 10'(o.x)) begin errors++; $display("FAIL clamp_x f%0d got=%0d exp=%0d", f, b_cx[1], o.x); end
      checks++; if (b_spr[1] !== 3'(o.spr)) begin errors++; $display("FAIL clamp_spr f%0d got=%0d exp=%0d", f, b_spr[1], o.spr); end
      eof_end(0);
    end
    checks++; if (b_cy[0] !== 10'd2) begin errors++; $display("FAIL clamp_other_y got=%0d exp=2", b_cy[0]); end
  endtask

  task automatic test_step_div();
    exp_t e, o;
    int y, div;
    apply_reset();
    c_dn[0] = 1'b1;
    y = 300; div = 0;
    for (int f = 0; f < 9; f++) begin
      if (div == 0) y++;
      div = (div + 1) % 3;
      e.x = 400; e.y = y; e.spr = 0;
      sb.push_back(e);
      eof_start();
      o = sb.pop_front();
      checks++; if (c_cy[0] !== 10'(o.y)) begin errors++; $display("FAIL div_y f%0d got=%0d exp=%0d", f, c_cy[0], o.y); end
      eof_end((f == 4) ? 3 : 0);
    end
    checks++; if (c_cy[0] !== 10'd303) begin errors++; $display("FAIL div_total got=%0d exp=303", c_cy[0]); end
  endtask

  task automatic test_multi_player();
    exp_t e, o;
    apply_reset();
    d_up[3] = 1'b1;
    d_rt[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.x = 400 + i * 50 + ((i == 2) ? 1 : 0);
      e.y = 300 - ((i == 3) ? 1 : 0);
      e.spr = (i == 2) ? 3 : ((i == 3) ? 0 : 2);
      sb.push_back(e);
    end
    eof_start();
    for (int i = 0; i < 4; i++) begin
      o = sb.pop_front();
      checks++; if (d_cx[i] !== 10'(o.x)) begin errors++; $display("FAIL multi_x[%0d] got=%0d exp=%0d", i, d_cx[i], o.x); end
      checks++; if (d_cy[i] !== 10'(o.y)) begin errors++; $display("FAIL multi_y[%0d] got=%0d exp=%0d", i, d_cy[i], o.y); end
      checks++; if (d_spr[i] !== 3'(o.spr)) begin errors++; $display("FAIL multi_spr[%0d] got=%0d exp=%0d", i, d_spr[i], o.spr); end
    end
    eof_end(0);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_frame_tick();
    test_walk_right();
    test_both_pressed();
    test_reset_mid();
    test_clamp_top();
    test_step_div();
    test_multi_player();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
